// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store controller for a single-port word Memory (cs = read, we = write, no byte enables).
// Sub-word stores use read-modify-write. Define MEM_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_access_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_signed_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic [WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_e           state_q;
  logic             we_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic [15:0]      wdata_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_data_q;
  logic             mem_cs_q;
  logic             mem_we_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] merge_d;

  // Lane extraction for loads and lane merge for sub-word stores, both from the word captured in CAP.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byte_sel = mem_data_i[{lane_q, 3'b000} +: 8];
    half_sel = mem_data_i[{lane_q[1], 4'b0000} +: 16];
    load_d   = mem_data_i;
    merge_d  = mem_data_i;
    case (size_q)
      SZ_BYTE: begin
        load_d = {{(WIDTH-8){signed_q & byte_sel[7]}}, byte_sel};
        merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_d = {{(WIDTH-16){signed_q & half_sel[15]}}, half_sel};
        merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  logic rsp_err_q;

  assign misalign = (req_size_i == SZ_HALF) ? req_addr_i[0]
                                            : (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (misalign) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else
`endif
            begin
              we_q       <= req_we_i;
              size_q     <= req_size_i;
              signed_q   <= req_signed_i;
              lane_q     <= req_addr_i[1:0];
              wdata_q    <= req_wdata_i[15:0];
              mem_addr_q <= {req_addr_i[WIDTH-1:2], 2'b00};
              // Word (and reserved-size) stores need no old data; everything else reads first.
              if (req_we_i && req_size_i[1]) begin
                mem_we_q   <= 1'b1;
                mem_data_q <= req_wdata_i;
                state_q    <= S_WR;
              end else begin
                mem_cs_q   <= 1'b1;
                state_q    <= S_RD;
              end
            end
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          if (we_q) begin
            mem_we_q   <= 1'b1;
            mem_data_q <= merge_d;
            state_q    <= S_WR;
          end else begin
            rsp_rdata_q <= load_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_WR: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_cs_o    = mem_cs_q;
  assign mem_we_o    = mem_we_q;
  assign mem_data_o  = mem_data_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
